// File: rtl/zero_skip_dispatcher.sv
// Zero-skipping activation/weight dispatcher: pairs each activation element with the current weight.
// Optional feature macro DISPATCHER_ZERO_SKIP_EN: when defined, zero-flagged elements are skipped.
module zero_skip_dispatcher #(
  parameter int DATA_WIDTH             = 8,
  parameter int GROUP_SIZE             = 4,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int ZERO_INFO              = GROUP_SIZE
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    configure,
  input  logic [LOG_MAX_ITERS-1:0]                num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]       num_reads_per_iter,
  input  logic [DATA_WIDTH*GROUP_SIZE+ZERO_INFO-1:0] act_data_in,
  input  logic                                    act_valid_in,
  output logic                                    act_avail_out,
  input  logic [DATA_WIDTH-1:0]                   weight_data_in,
  input  logic                                    weight_valid_in,
  output logic                                    weight_avail_out,
  output logic [2*DATA_WIDTH-1:0]                 data_out,
  output logic                                    valid_out,
  input  logic                                    avail_in
);

  localparam int ELEM_BITS = DATA_WIDTH * GROUP_SIZE;
  localparam int IDX_W     = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, WEIGHT, ACT, EMIT} state_t;

  state_t                            state_q, state_d;
  logic [LOG_MAX_ITERS-1:0]          iters_cfg_q, iters_cfg_d, iter_cnt_q, iter_cnt_d;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_cfg_q, reads_cfg_d, read_cnt_q, read_cnt_d;
  logic [DATA_WIDTH-1:0]             weight_q, weight_d;
  logic [ELEM_BITS-1:0]              elems_q, elems_d;
  logic [GROUP_SIZE-1:0]             remaining_q, remaining_d;
  logic [2*DATA_WIDTH-1:0]           data_q, data_d;
  logic                              valid_q, valid_d;

  logic [GROUP_SIZE-1:0] skip_mask, act_pending;
  logic [IDX_W-1:0]      act_idx, rem_idx;
  logic                  emit_done;

`ifdef DISPATCHER_ZERO_SKIP_EN
  assign skip_mask = GROUP_SIZE'(act_data_in[ELEM_BITS +: ZERO_INFO]);
`else
  logic unused_flags;
  assign skip_mask    = '0;
  assign unused_flags = ^act_data_in[ELEM_BITS +: ZERO_INFO];
`endif

  // Lowest set bit wins, so elements leave in ascending index order.
  function automatic logic [IDX_W-1:0] first_set(input logic [GROUP_SIZE-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
      if (v[k]) idx = IDX_W'(k);
    end
    return idx;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pick(input logic [ELEM_BITS-1:0] e,
                                                 input logic [IDX_W-1:0]     idx);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      if (idx == IDX_W'(k)) r = e[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    iters_cfg_d = iters_cfg_q;
    reads_cfg_d = reads_cfg_q;
    iter_cnt_d  = iter_cnt_q;
    read_cnt_d  = read_cnt_q;
    weight_d    = weight_q;
    elems_d     = elems_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    act_pending = ~skip_mask;
    act_idx     = first_set(act_pending);
    rem_idx     = first_set(remaining_q);
    emit_done   = !valid_q || (avail_in && (remaining_q == '0));

    unique case (state_q)
      IDLE: ;
      WEIGHT: begin
        if (weight_valid_in) begin
          weight_d = weight_data_in;
          state_d  = ACT;
        end
      end
      ACT: begin
        if (act_valid_in) begin
          elems_d     = act_data_in[ELEM_BITS-1:0];
          read_cnt_d  = read_cnt_q + 1'b1;
          valid_d     = |act_pending;
          remaining_d = act_pending & ~(GROUP_SIZE'(1) << act_idx);
          if (|act_pending) data_d = {weight_q, pick(act_data_in[ELEM_BITS-1:0], act_idx)};
          state_d     = EMIT;
        end
      end
      EMIT: begin
        // The element on data_out is already removed from remaining_q.
        if (valid_q && avail_in && (remaining_q != '0)) begin
          data_d      = {weight_q, pick(elems_q, rem_idx)};
          remaining_d = remaining_q & ~(GROUP_SIZE'(1) << rem_idx);
        end
        if (emit_done) begin
          valid_d = 1'b0;
          if (read_cnt_q < reads_cfg_q) begin
            state_d = ACT;
          end else begin
            iter_cnt_d = iter_cnt_q + 1'b1;
            read_cnt_d = '0;
            state_d    = (iter_cnt_d < iters_cfg_q) ? WEIGHT : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (configure) begin
      iters_cfg_d = num_iters;
      reads_cfg_d = num_reads_per_iter;
      iter_cnt_d  = '0;
      read_cnt_d  = '0;
      valid_d     = 1'b0;
      remaining_d = '0;
      state_d     = ((num_iters != '0) && (num_reads_per_iter != '0)) ? WEIGHT : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the element buffer is a handful of flops, so it is reset with everything else.
      state_q     <= IDLE;
      iters_cfg_q <= '0;
      reads_cfg_q <= '0;
      iter_cnt_q  <= '0;
      read_cnt_q  <= '0;
      weight_q    <= '0;
      elems_q     <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q     <= state_d;
      iters_cfg_q <= iters_cfg_d;
      reads_cfg_q <= reads_cfg_d;
      iter_cnt_q  <= iter_cnt_d;
      read_cnt_q  <= read_cnt_d;
      weight_q    <= weight_d;
      elems_q     <= elems_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign act_avail_out    = (state_q == ACT);
  assign weight_avail_out = (state_q == WEIGHT);
  assign data_out         = data_q;
  assign valid_out        = valid_q;

endmodule

// File: tb/tb_zero_skip_dispatcher.sv
// Self-checking bench for zero_skip_dispatcher: directed scenarios plus random runs,
// checked against a list-based model of the emitted (weight, element) pairs.
module tb_zero_skip_dispatcher;

  localparam int DW = 8;
  localparam int G  = 4;
`ifdef DISPATCHER_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, configure;
  logic [15:0]     num_iters, num_reads_per_iter;
  logic [DW*G+G-1:0] act_data_in;
  logic            act_valid_in, act_avail_out;
  logic [DW-1:0]   weight_data_in;
  logic            weight_valid_in, weight_avail_out;
  logic [2*DW-1:0] data_out;
  logic            valid_out, avail_in;

  int total = 0;
  int bad   = 0;
  int pairs = 0;
  logic [15:0] exp_q[$];

  zero_skip_dispatcher dut (
    .clk(clk), .rst(rst), .configure(configure),
    .num_iters(num_iters), .num_reads_per_iter(num_reads_per_iter),
    .act_data_in(act_data_in), .act_valid_in(act_valid_in), .act_avail_out(act_avail_out),
    .weight_data_in(weight_data_in), .weight_valid_in(weight_valid_in),
    .weight_avail_out(weight_avail_out),
    .data_out(data_out), .valid_out(valid_out), .avail_in(avail_in)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cfg(input int iters, input int reads);
    configure          = 1'b1;
    num_iters          = 16'(iters);
    num_reads_per_iter = 16'(reads);
    @(negedge clk);
    configure = 1'b0;
    check("cfg_weight_avail", weight_avail_out, (iters != 0) && (reads != 0));
    check("cfg_valid", valid_out, 0);
  endtask

  task automatic send_weight(input logic [7:0] w);
    int n = 0;
    while (!weight_avail_out && n < 50) begin @(negedge clk); n++; end
    check("weight_wait", weight_avail_out, 1);
    check("avail_excl", act_avail_out, 0);
    weight_data_in  = w;
    weight_valid_in = 1'b1;
    @(negedge clk);
    weight_valid_in = 1'b0;
    weight_data_in  = 8'($urandom);
    check("weight_to_act", act_avail_out, 1);
  endtask

  // Model: every element in index order, minus zero-flagged ones when skipping is on.
  task automatic do_group(input logic [31:0] elems, input logic [7:0] w,
                          input bit more_reads, input bit more_iters, input int stall);
    logic [3:0]  flags;
    logic [15:0] held, e;
    bit          hold, a;
    int          n;
    for (int k = 0; k < G; k++) flags[k] = (elems[k*DW +: DW] == 8'd0);
    exp_q.delete();
    for (int k = 0; k < G; k++)
      if (!(SKIP && flags[k])) exp_q.push_back({w, elems[k*DW +: DW]});

    n = 0;
    while (!act_avail_out && n < 50) begin @(negedge clk); n++; end
    check("act_wait", act_avail_out, 1);
    act_data_in  = {flags, elems};
    act_valid_in = 1'b1;
    @(negedge clk);
    act_valid_in = 1'b0;
    act_data_in  = {4'($urandom), 32'($urandom)};
    check("first_valid", valid_out, exp_q.size() != 0);

    if (exp_q.size() == 0) begin
      check("empty_no_act", act_avail_out, 0);
      @(negedge clk);
    end else begin
      n = 0; hold = 1'b0; held = '0;
      while (exp_q.size() != 0 && n < 200) begin
        if (hold) check("hold_stable", {valid_out, data_out}, {1'b1, held});
        a = (n < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
        avail_in = a;
        if (valid_out && a) begin
          e = exp_q.pop_front();
          check("pair", data_out, e);
          pairs++;
          hold = 1'b0;
        end else begin
          hold = valid_out;
          held = data_out;
        end
        @(negedge clk);
        n++;
      end
      check("emit_budget", n < 200, 1);
      avail_in = 1'($urandom_range(0, 1));
    end
    check("group_end_valid", valid_out, 0);
    check("group_end_act", act_avail_out, more_reads);
    check("group_end_weight", weight_avail_out, !more_reads && more_iters);
  endtask

  function automatic logic [7:0] rand_elem();
    return ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
  endfunction

  task automatic run(input int iters, input int reads, input bit directed);
    logic [7:0]  w;
    logic [31:0] elems;
    int          p0;
    cfg(iters, reads);
    for (int it = 0; it < iters; it++) begin
      w = directed ? 8'(it + 1) : 8'($urandom_range(1, 255));
      send_weight(w);
      p0 = pairs;
      for (int r = 0; r < reads; r++) begin
        if (directed)
          elems = (it == 0) ? {8'(r + 1), 8'(r + 1), 8'(r), 8'd0}
                            : {8'(r + 3), 8'(r + 1), 8'(r + 2), 8'd0};
        else
          elems = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
        do_group(elems, w, r < reads - 1, it < iters - 1, 0);
      end
      if (directed)
        check("iter_pair_count", pairs - p0, SKIP ? ((it == 0) ? 11 : 12) : 16);
    end
  endtask

  initial begin
    rst = 1'b1; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
    act_data_in = '0; act_valid_in = 1'b0; weight_data_in = '0;
    weight_valid_in = 1'b0; avail_in = 1'b0;
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_act_avail", act_avail_out, 0);
    check("rst_weight_avail", weight_avail_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Two iterations of four reads with the reference group pattern.
    run(2, 4, 1'b1);
    check("run_idle_act", act_avail_out, 0);

    // Zero counts configure straight into IDLE.
    cfg(0, 3);
    cfg(2, 0);
    check("zero_cfg_act", act_avail_out, 0);

    // All-zero group, then a group with interleaved zeros.
    cfg(1, 2);
    send_weight(8'd9);
    do_group(32'h0000_0000, 8'd9, 1'b1, 1'b0, 0);
    do_group({8'd2, 8'd0, 8'd1, 8'd0}, 8'd9, 1'b0, 1'b0, 0);

    // Back-pressure: output must hold for three stalled cycles.
    cfg(1, 1);
    send_weight(8'd3);
    do_group({8'd0, 8'd7, 8'd0, 8'd5}, 8'd3, 1'b0, 1'b0, 3);

    // Reset in the middle of EMIT aborts the run.
    cfg(1, 2);
    send_weight(8'd4);
    act_data_in  = {4'b0000, 32'h0403_0201};
    act_valid_in = 1'b1;
    @(negedge clk);
    act_valid_in = 1'b0;
    check("pre_rst_valid", valid_out, 1);
    avail_in = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_act", act_avail_out, 0);
    check("mid_rst_weight", weight_avail_out, 0);
    act_valid_in = 1'b1; weight_valid_in = 1'b1; avail_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {valid_out, act_avail_out, weight_avail_out}, 0);
    end
    act_valid_in = 1'b0; weight_valid_in = 1'b0; avail_in = 1'b0;

    // Random runs.
    for (int t = 0; t < 6; t++)
      run($urandom_range(1, 3), $urandom_range(1, 4), 1'b0);
    check("final_idle", {valid_out, act_avail_out, weight_avail_out}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
